// File: rtl/sdram_wbarbiter.sv
// Two-master pipelined Wishbone arbiter in front of the SDRAM slave port.
// Round-robin grant, outstanding-request tracking and a no-response timeout abort.
module sdram_wbarbiter #(
  parameter  int AW      = 26,
  parameter  int DW      = 32,
  parameter  int LGOUT   = 5,
  parameter  int TIMEOUT = 10000,
  localparam int SELW    = DW / 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  // master A
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [SELW-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  // master B
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [SELW-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  // SDRAM slave
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [SELW-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, ABORT} state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;         // 0 = A, 1 = B
  logic             last_grant, last_nxt;     // 0 = A, 1 = B
  logic [LGOUT-1:0] count, count_nxt;
  logic [TW-1:0]    timer, timer_nxt;

  logic own, x_cyc, x_stb, full, count_nz;
  logic resp_any, ack_fwd, err_fwd, timeout_hit, fwd_stb, accept;

  assign own         = (state == OWN_A) || (state == OWN_B);
  assign x_cyc       = owner ? i_b_cyc : i_a_cyc;
  assign x_stb       = owner ? i_b_stb : i_a_stb;
  assign full        = (count == {LGOUT{1'b1}});
  assign count_nz    = (count != '0);
  assign resp_any    = i_wb_ack | i_wb_err;
  assign ack_fwd     = own & i_wb_ack & count_nz;
  assign err_fwd     = own & i_wb_err & count_nz;
  // An ack or err arriving on the deadline cycle beats the timeout.
  assign timeout_hit = own & count_nz & ~resp_any & (timer == TIMER_LAST);
  assign fwd_stb     = own & x_cyc & x_stb & ~full & ~timeout_hit;
  assign accept      = fwd_stb & ~i_wb_stall;

  // NOTE: async reset in the sensitivity list, and every register uses <= so all
  // state updates see the same pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      timer      <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
      count      <= count_nxt;
      timer      <= timer_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_grant;
    count_nxt = count;
    timer_nxt = timer;
    unique case (state)
      IDLE: begin
        count_nxt = '0;
        timer_nxt = '0;
        if (i_a_cyc && (!i_b_cyc || last_grant)) begin
          state_nxt = OWN_A;
          owner_nxt = 1'b0;
          last_nxt  = 1'b0;
        end else if (i_b_cyc) begin
          state_nxt = OWN_B;
          owner_nxt = 1'b1;
          last_nxt  = 1'b1;
        end
      end
      OWN_A, OWN_B: begin
        if (!x_cyc) begin
          state_nxt = IDLE;
          count_nxt = '0;
          timer_nxt = '0;
        end else if (timeout_hit || err_fwd) begin
          state_nxt = ABORT;
          count_nxt = '0;
          timer_nxt = '0;
        end else begin
          unique case ({accept, ack_fwd})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
          endcase
          timer_nxt = (resp_any || !count_nz) ? '0 : timer + 1'b1;
        end
      end
      ABORT: begin
        count_nxt = '0;
        timer_nxt = '0;
        if (!x_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_a_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    if (own) begin
      o_wb_cyc = x_cyc & ~timeout_hit;
      o_wb_stb = fwd_stb;
      if (owner) begin
        o_b_stall = i_wb_stall | full | timeout_hit;
        o_b_ack   = ack_fwd;
        o_b_err   = err_fwd | timeout_hit;
      end else begin
        o_a_stall = i_wb_stall | full | timeout_hit;
        o_a_ack   = ack_fwd;
        o_a_err   = err_fwd | timeout_hit;
      end
    end
  end

  // Request fields follow B only while B actually owns the bus.
  logic use_b;
  assign use_b     = own & owner;
  assign o_wb_we   = use_b ? i_b_we   : i_a_we;
  assign o_wb_addr = use_b ? i_b_addr : i_a_addr;
  assign o_wb_data = use_b ? i_b_data : i_a_data;
  assign o_wb_sel  = use_b ? i_b_sel  : i_a_sel;
  assign o_a_data  = i_wb_data;
  assign o_b_data  = i_wb_data;

endmodule

// File: tb/tb_sdram_wbarbiter.sv
// Directed bench for sdram_wbarbiter: grant order, pipelining, full, timeout,
// slave error and mid-burst reset, with hand-computed expectations.
module tb_sdram_wbarbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, wb_rdata;
  logic [SW-1:0] a_sel, b_sel;
  logic          wb_stall, wb_ack, wb_err;

  logic          a_stall, a_ack, a_err, b_stall, b_ack, b_err;
  logic [DW-1:0] a_rdata, b_rdata, wb_wdata;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [SW-1:0] wb_sel;

  logic          s_a_stall, s_a_ack, s_a_err, s_b_stall, s_b_ack, s_b_err;
  logic [DW-1:0] s_a_rdata, s_b_rdata, s_wb_wdata;
  logic          s_wb_cyc, s_wb_stb, s_wb_we;
  logic [AW-1:0] s_wb_addr;
  logic [SW-1:0] s_wb_sel;

  int       checks = 0;
  int       errors = 0;
  logic [2:0] pipe;
  bit       auto_ack;
  int       ack_issue;
  int       nack;
  int       acc_n;

  always #5 clk = ~clk;

  sdram_wbarbiter #(.AW(AW), .DW(DW), .LGOUT(5), .TIMEOUT(16)) u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_wdata), .i_a_sel(a_sel),
    .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err), .o_a_data(a_rdata),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_wdata), .i_b_sel(b_sel),
    .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err), .o_b_data(b_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );

  sdram_wbarbiter #(.AW(AW), .DW(DW), .LGOUT(2), .TIMEOUT(16)) u_small (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_wdata), .i_a_sel(a_sel),
    .o_a_stall(s_a_stall), .o_a_ack(s_a_ack), .o_a_err(s_a_err), .o_a_data(s_a_rdata),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_wdata), .i_b_sel(b_sel),
    .o_b_stall(s_b_stall), .o_b_ack(s_b_ack), .o_b_err(s_b_err), .o_b_data(s_b_rdata),
    .o_wb_cyc(s_wb_cyc), .o_wb_stb(s_wb_stb), .o_wb_we(s_wb_we), .o_wb_addr(s_wb_addr),
    .o_wb_data(s_wb_wdata), .o_wb_sel(s_wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Advance one cycle; the auto slave acks each accepted request 3 cycles later.
  task automatic adv();
    logic acc;
    acc = wb_cyc & wb_stb & ~wb_stall;
    @(posedge clk);
    #1;
    pipe = {pipe[1:0], acc};
    if (auto_ack) begin
      wb_ack = pipe[2];
      if (pipe[2]) begin
        wb_rdata = 32'hDA7A_0000 + 32'(ack_issue);
        ack_issue++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    auto_ack = 1'b0; pipe = '0;
    settle();
    adv();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_addr = '0; b_addr = '0; a_wdata = 32'h1111_AAAA; b_wdata = 32'h2222_BBBB;
    a_sel = 4'hF; b_sel = 4'h3; wb_rdata = '0; ack_issue = 0; nack = 0; acc_n = 0;
    do_reset();
    rst = 1'b1;
    settle();
    check("rst_wb_cyc", wb_cyc, 0);
    check("rst_a_stall", a_stall, 1);
    check("rst_b_stall", b_stall, 1);
    check("rst_a_ack", a_ack, 0);
    adv();
    rst = 1'b0;

    // A only: four pipelined reads, acks three cycles after acceptance
    auto_ack = 1'b1; pipe = '0; ack_issue = 0; nack = 0;
    a_cyc = 1'b1;
    settle();
    check("t1_lat_cyc", wb_cyc, 0);
    check("t1_lat_stall", a_stall, 1);
    adv();
    for (int i = 0; i < 4; i++) begin
      a_stb = 1'b1;
      a_addr = AW'(32'h100 + i);
      settle();
      check("t1_a_stall", a_stall, 0);
      check("t1_wb_stb", wb_stb, 1);
      check("t1_wb_addr", 32'(wb_addr), 32'h100 + i);
      check("t1_b_stall", b_stall, 1);
      if (a_ack) begin
        check("t1_rdata", a_rdata, 32'hDA7A_0000 + 32'(nack));
        nack++;
      end
      adv();
    end
    a_stb = 1'b0;
    for (int k = 0; k < 10 && nack < 4; k++) begin
      settle();
      check("t1_b_stall", b_stall, 1);
      if (a_ack) begin
        check("t1_rdata", a_rdata, 32'hDA7A_0000 + 32'(nack));
        nack++;
      end
      adv();
    end
    check("t1_nack", nack, 4);
    auto_ack = 1'b0;
    wb_ack = 1'b1;
    settle();
    check("t1_stray_ack", a_ack, 0);
    check("t1_still_cyc", wb_cyc, 1);
    adv();
    wb_ack = 1'b0;
    a_cyc = 1'b0;
    settle();
    check("t1_drop_cyc", wb_cyc, 0);
    adv();

    // Simultaneous request after reset, then round-robin
    do_reset();
    a_addr = 26'h111; b_addr = 26'h222;
    a_cyc = 1'b1; b_cyc = 1'b1;
    settle();
    check("t2_idle_cyc", wb_cyc, 0);
    adv();
    settle();
    check("t2_a_grant", a_stall, 0);
    check("t2_b_wait", b_stall, 1);
    check("t2_addr_a", 32'(wb_addr), 32'h111);
    adv();
    a_cyc = 1'b0;
    settle();
    check("t2_a_drop", wb_cyc, 0);
    adv();
    settle();
    check("t2_gap_cyc", wb_cyc, 0);
    check("t2_gap_b", b_stall, 1);
    adv();
    settle();
    check("t2_b_cyc", wb_cyc, 1);
    check("t2_b_grant", b_stall, 0);
    check("t2_a_wait", a_stall, 1);
    check("t2_addr_b", 32'(wb_addr), 32'h222);
    b_cyc = 1'b0;
    adv();
    a_cyc = 1'b1; b_cyc = 1'b1;
    settle();
    adv();
    settle();
    check("t2_rr_a", a_stall, 0);
    check("t2_rr_b", b_stall, 1);
    a_cyc = 1'b0; b_cyc = 1'b0;
    adv();
    adv();

    // LGOUT=2: three outstanding fill the counter
    do_reset();
    a_cyc = 1'b1;
    adv();
    a_stb = 1'b1; acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t3_stall", s_a_stall, (i >= 3) ? 1 : 0);
      acc_n += int'(s_wb_stb & ~wb_stall);
      adv();
    end
    check("t3_accepted", acc_n, 3);
    wb_ack = 1'b1;
    settle();
    check("t3_ack", s_a_ack, 1);
    check("t3_ack_stall", s_a_stall, 1);
    adv();
    wb_ack = 1'b0;
    settle();
    check("t3_reopen", s_a_stall, 0);
    check("t3_reopen_stb", s_wb_stb, 1);
    adv();
    settle();
    check("t3_refull", s_a_stall, 1);
    a_stb = 1'b0; a_cyc = 1'b0;
    adv();

    // TIMEOUT=16: one write, never acked
    do_reset();
    a_cyc = 1'b1;
    adv();
    a_stb = 1'b1; a_we = 1'b1;
    settle();
    check("t4_wb_we", wb_we, 1);
    check("t4_wb_stb", wb_stb, 1);
    adv();
    a_stb = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      settle();
      check("t4_err", a_err, (k == 16) ? 1 : 0);
      if (k >= 15) check("t4_cyc", wb_cyc, (k == 16) ? 0 : 1);
      adv();
    end
    settle();
    check("t4_abort_cyc", wb_cyc, 0);
    check("t4_abort_stall", a_stall, 1);
    check("t4_abort_err", a_err, 0);
    adv();
    wb_ack = 1'b1;
    settle();
    check("t4_late_ack", a_ack, 0);
    adv();
    wb_ack = 1'b0; a_cyc = 1'b0; a_we = 1'b0;
    settle();
    adv();
    a_cyc = 1'b1;
    settle();
    check("t4_idle_cyc", wb_cyc, 0);
    adv();
    settle();
    check("t4_regrant", wb_cyc, 1);
    a_cyc = 1'b0;
    adv();

    // Slave err on the second of three reads; B waits
    do_reset();
    a_cyc = 1'b1; b_cyc = 1'b1;
    adv();
    a_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      adv();
    end
    a_stb = 1'b0; wb_ack = 1'b1;
    settle();
    check("t5_ack", a_ack, 1);
    adv();
    wb_ack = 1'b0; wb_err = 1'b1;
    settle();
    check("t5_err", a_err, 1);
    check("t5_b_wait", b_stall, 1);
    adv();
    wb_err = 1'b0;
    settle();
    check("t5_abort_cyc", wb_cyc, 0);
    check("t5_abort_b", b_stall, 1);
    adv();
    settle();
    check("t5_hold_cyc", wb_cyc, 0);
    adv();
    a_cyc = 1'b0;
    settle();
    check("t5_release_cyc", wb_cyc, 0);
    adv();
    settle();
    check("t5_idle_b", b_stall, 1);
    adv();
    settle();
    check("t5_b_grant", b_stall, 0);
    check("t5_b_cyc", wb_cyc, 1);
    b_cyc = 1'b0;
    adv();

    // Reset mid-burst with two outstanding
    do_reset();
    a_cyc = 1'b1;
    adv();
    a_stb = 1'b1;
    settle();
    adv();
    settle();
    adv();
    a_stb = 1'b0;
    settle();
    check("t6_pre_cyc", wb_cyc, 1);
    rst = 1'b1;
    #1;
    check("t6_async_cyc", wb_cyc, 0);
    check("t6_async_a", a_stall, 1);
    check("t6_async_b", b_stall, 1);
    adv();
    rst = 1'b0; wb_ack = 1'b1; b_cyc = 1'b1;
    settle();
    check("t6_idle_ack", a_ack, 0);
    adv();
    settle();
    check("t6_stray_ack", a_ack, 0);
    check("t6_a_grant", a_stall, 0);
    check("t6_b_wait", b_stall, 1);
    wb_ack = 1'b0; a_cyc = 1'b0; b_cyc = 1'b0;
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_wbarbiter.md
Name: sdram_wbarbiter

Overview:
- Two-master Wishbone (pipelined) arbiter feeding the single SDRAM Wishbone slave port of the MIG/AXI bridge.
- Sits directly upstream of that port, in the SDRAM user clock domain.
- Grants one master at a time using round-robin and tracks outstanding requests.
- Aborts the bus with an error if the memory stops acknowledging, e.g. while it is held in reset for recalibration.

Parameters:
- AW, 26, Wishbone word-address width; matches the SDRAM slave port.
- DW, 32, Wishbone data width. SELW = DW/8 (derived, not overridable).
- LGOUT, 5, log2 of the outstanding-request counter range; maximum outstanding = 2^LGOUT - 1.
- TIMEOUT, 10000, cycles with requests outstanding and no ack/err before an abort; must be >= 2.

Ports:
- i_clk  in  1  single clock (SDRAM user clock).
- i_reset  in  1  asynchronous, active-high reset.
- i_a_cyc, i_a_stb, i_a_we  in  1 each  master A bus controls.
- i_a_addr  in  AW  master A address.
- i_a_data  in  DW  master A write data.
- i_a_sel  in  SELW  master A byte selects.
- o_a_stall, o_a_ack, o_a_err  out  1 each  master A responses.
- o_a_data  out  DW  master A read data.
- i_b_*, o_b_*  as for master A  master B.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  to SDRAM slave.
- o_wb_addr  out  AW  to SDRAM slave.
- o_wb_data  out  DW  to SDRAM slave.
- o_wb_sel  out  SELW  to SDRAM slave.
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  from SDRAM slave.
- i_wb_data  in  DW  read data from SDRAM slave.

Behaviour:
- Registered state: IDLE, OWN_A, OWN_B, ABORT, plus owner flag, last-grant flag, outstanding count (LGOUT bits) and timeout counter.
- Reset (async): state IDLE, count 0, timer 0, last-grant = B, so A wins the first tie.
- In IDLE and ABORT: o_wb_cyc=0, o_wb_stb=0; both o_x_stall=1; all o_x_ack/o_x_err=0.
- o_a_data = o_b_data = i_wb_data at all times. o_wb_addr/data/sel/we mux from the owner; they come from A when no master owns the bus.
- IDLE transitions, taken on the clock edge:
  - Only A has cyc: go to OWN_A.
  - Only B has cyc: go to OWN_B.
  - Both have cyc: grant the master that is not last-grant.
  - Last-grant updates on every grant.
  - Minimum grant latency is 1 cycle; the master stays stalled during IDLE.
- OWN_X forwarding:
  - o_wb_cyc = i_x_cyc; o_wb_stb = i_x_cyc & i_x_stb & !full.
  - o_x_stall = i_wb_stall | full.
  - o_x_ack = i_wb_ack & count!=0; o_x_err = i_wb_err & count!=0.
  - The other master sees stall=1, ack=0, err=0.
- full = (count == 2^LGOUT-1).
- Count update:
  - +1 on o_wb_stb & !i_wb_stall.
  - -1 on a forwarded ack/err.
  - Both in one cycle: unchanged.
  - Stray ack/err with count 0: dropped, count stays 0.
- Owner drops cyc: o_wb_cyc=0 that same cycle; next state IDLE; count and timer clear. No direct handover, so the slave always sees at least one cycle of cyc low between owners.
- Timer:
  - Increments each OWN_X cycle with count!=0 and no ack/err.
  - Clears on any ack/err or when count==0.
  - When the timer reaches TIMEOUT-1 without an ack: o_x_err=1 for that cycle, o_wb_cyc forced 0, next state ABORT, count and timer clear.
  - Ack and timeout in the same cycle: the ack wins and the timer clears.
- Slave i_wb_err in OWN_X: forwarded as err; next state ABORT; count clears.
- ABORT: hold until the aborted owner's cyc is low, then IDLE. Acks arriving in ABORT are dropped.
- Reset mid-transfer: immediate IDLE; o_wb_cyc drops asynchronously; outstanding acks are discarded afterward because count=0.

Test Plan:
- A only: 4 pipelined reads, addresses 0x100..0x103, slave acks 3 cycles later → 4 acks on A, data passed through, B stall=1 throughout, count back to 0.
- A and B raise cyc in the same cycle after reset → A granted; after A drops cyc, o_wb_cyc low for 1 cycle, then B granted. Repeat with both high → A granted again (round-robin).
- LGOUT=2, slave never acks while stall=0 → exactly 3 stb accepted, then o_a_stall=1; one ack → one more accepted.
- TIMEOUT=16, one write, no ack → o_a_err pulses on the 16th cycle after the request; o_wb_cyc=0; state ABORT until A drops cyc; a late ack is not forwarded.
- Slave err on the 2nd of 3 reads → A sees ack, then err; o_wb_cyc drops; B (waiting) is granted only after A drops cyc.
- i_reset asserted mid-burst with 2 outstanding → o_wb_cyc=0 and both stalls=1 immediately; acks after release are ignored; the next grant goes to A.
